// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_pkg
//  Description : Shared sizing and loader state encoding so the program RAM
//                and its loader agree on geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package sap_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 16;

    // Loader sequence: one byte walks SETUP -> STROBE -> HOLD -> VERIFY.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SETUP     = 3'd2,
        STROBE    = 3'd3,
        HOLD      = 3'd4,
        VERIFY    = 3'd5,
        FINISH    = 3'd6
    } loader_state_t;

endpackage : sap_pkg
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader
//  Description : Streams LAST_ADDR+1 bytes over valid/ready into the 16x8
//                program RAM, reading each word back, then returns the RAM
//                to run mode. All RAM-facing outputs are driven from flops.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int LAST_ADDR = RAM_DEPTH - 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_read_write,
    output logic              ram_run_prog,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(LAST_ADDR);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_rw;
    logic              r_run_prog;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a byte is only taken while waiting for one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (start)    w_next = WAIT_BYTE;
            WAIT_BYTE: if (in_valid) w_next = SETUP;
            SETUP:     w_next = STROBE;
            STROBE:    w_next = HOLD;
            HOLD:      w_next = VERIFY;
            VERIFY:    w_next = (r_addr == c_last_addr) ? FINISH : WAIT_BYTE;
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; the write strobe is low only while in STROBE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_rw       <= 1'b1;
            r_run_prog <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_rw   <= (w_next == STROBE) ? 1'b0 : 1'b1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr     <= '0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_run_prog <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                    end
                end
                VERIFY: begin
                    if (ram_q != r_data) begin
                        r_err <= 1'b1;
                    end
                    if (r_addr == c_last_addr) begin
                        r_done <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                FINISH: begin
                    r_run_prog <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (r_state == WAIT_BYTE);
    assign ram_addr       = r_addr;
    assign ram_data       = r_data;
    assign ram_read_write = r_rw;
    assign ram_run_prog   = r_run_prog;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule : ram_loader
`default_nettype wire
